// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-side hazard/forward bundle.
// master = pipeline control, slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall;
  logic                  ex_bubble;
  logic                  fwd_a_sel;
  logic                  fwd_a_src;
  logic                  fwd_b_sel;
  logic                  fwd_b_src;

  modport master (
    output id_valid, id_rs1, id_rs1_used,
    output id_rs2, id_rs2_used, id_rd,
    output id_we, id_is_load, flush,
    input  stall, ex_bubble,
    input  fwd_a_sel, fwd_a_src,
    input  fwd_b_sel, fwd_b_src
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used,
    input  id_rs2, id_rs2_used, id_rd,
    input  id_we, id_is_load, flush,
    output stall, ex_bubble,
    output fwd_a_sel, fwd_a_src,
    output fwd_b_sel, fwd_b_src
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall and EX operand-forward selects.
// Define HAZ_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 3
) (
  input  logic clk,
  input  logic rst,
  hazard_forward_unit_if.slave hif
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } ent_t;

  function automatic logic hit(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used,
    input ent_t                  e
  );
    return used && e.v && e.we &&
           (e.rd != '0) && (e.rd == rs);
  endfunction

  ent_t ex_q, ex_d, mem_q;
  logic bub_q;
  logic a_sel_q, a_src_q, a_sel_d, a_src_d;
  logic b_sel_q, b_src_q, b_sel_d, b_src_d;
  logic a_ex, a_mem, b_ex, b_mem;
  logic stall_c, bub_c;

  assign a_ex  = hit(hif.id_rs1, hif.id_rs1_used, ex_q);
  assign a_mem = hit(hif.id_rs1, hif.id_rs1_used, mem_q);
  assign b_ex  = hit(hif.id_rs2, hif.id_rs2_used, ex_q);
  assign b_mem = hit(hif.id_rs2, hif.id_rs2_used, mem_q);

  assign stall_c = hif.id_valid && !hif.flush &&
                   ex_q.ld && (a_ex || b_ex);
  assign bub_c   = stall_c || hif.flush || !hif.id_valid;

  always_comb begin
    ex_d = '0;
    if (!bub_c) begin
      ex_d.v  = 1'b1;
      ex_d.rd = hif.id_rd;
      ex_d.we = hif.id_we;
      ex_d.ld = hif.id_is_load;
    end
  end

  // EX producer is nearer than MEM, so it takes priority.
  always_comb begin
    a_sel_d = 1'b0;
    a_src_d = 1'b0;
    priority case (1'b1)
      bub_c: ;
      a_ex:  a_sel_d = 1'b1;
      a_mem: begin
        a_sel_d = 1'b1;
        a_src_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    b_sel_d = 1'b0;
    b_src_d = 1'b0;
    priority case (1'b1)
      bub_c: ;
      b_ex:  b_sel_d = 1'b1;
      b_mem: begin
        b_sel_d = 1'b1;
        b_src_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      bub_q   <= 1'b1;
      a_sel_q <= 1'b0;
      a_src_q <= 1'b0;
      b_sel_q <= 1'b0;
      b_src_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      bub_q   <= bub_c;
      a_sel_q <= a_sel_d;
      a_src_q <= a_src_d;
      b_sel_q <= b_sel_d;
      b_src_q <= b_src_d;
    end
  end

  assign hif.stall     = stall_c;
  assign hif.ex_bubble = bub_q;
  assign hif.fwd_a_sel = a_sel_q;
  assign hif.fwd_a_src = a_src_q;
  assign hif.fwd_b_sel = b_sel_q;
  assign hif.fwd_b_src = b_src_q;

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (stall_c && cnt_q != 16'hFFFF)
               ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Hazard detection and operand-forwarding control for the 8-bit pipelined core (IF/ID/EX/MEM/WB).
- Sits in ID, directly upstream of the EX-stage 8-bit 2:1 operand muxes.
- Tracks the destination registers of the instructions in EX and MEM.
- Drives, one cycle later, the select lines of two cascaded 2:1 muxes per ALU operand, and raises a load-use stall.

Parameters:
REG_ADDR_W, 3, register-address width (8 architectural registers; R0 reads as zero).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_rs1  input  REG_ADDR_W  source A register
id_rs1_used  input  1  instruction reads rs1
id_rs2  input  REG_ADDR_W  source B register
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_ADDR_W  destination register
id_we  input  1  instruction writes rd
id_is_load  input  1  instruction is a load (result available only at WB)
flush  input  1  branch taken; ID instruction is squashed
stall  output  1  combinational; freeze PC and IF/ID, insert bubble into ID/EX
ex_bubble  output  1  registered; EX holds a bubble
fwd_a_sel  output  1  registered; operand-A 2:1 mux: 0 = register file, 1 = forwarded value
fwd_a_src  output  1  registered; forward-source 2:1 mux: 0 = EX/MEM ALU result, 1 = WB result
fwd_b_sel  output  1  as fwd_a_sel, operand B
fwd_b_src  output  1  as fwd_a_src, operand B

Behaviour:
- Internal tracking entries: ex_e and mem_e, each {v, rd, we, ld}. They describe the instructions now in EX and MEM.
- A writer qualifies only if v && we && rd != 0. R0 never causes forwarding or stalling.
- Match(rs, used, e) = used && writer(e) && e.rd == rs.
- Load-use stall: stall = id_valid && !flush && ex_e.ld && (Match(rs1,rs1_used,ex_e) || Match(rs2,rs2_used,ex_e)).
- Advance, every posedge when not in reset:
  - mem_e <= ex_e.
  - ex_e <= bubble (v=0) if stall || flush || !id_valid.
  - Otherwise ex_e <= {1, id_rd, id_we, id_is_load}.
- Forwarding decision per operand, computed in ID and registered for EX:
  - If Match(rs, used, ex_e) and not stalling: sel=1, src=0. The producer will be in MEM.
  - Else if Match(rs, used, mem_e): sel=1, src=1. The producer will be in WB.
  - Else sel=0, src=0.
  - Nearer producer (ex_e) always wins over mem_e.
- When EX receives a bubble: all fwd_* <= 0 and ex_bubble <= 1. Otherwise ex_bubble <= 0.
- Latency: stall is combinational in the same cycle. fwd_* and ex_bubble are valid the cycle after ID evaluation, aligned with the instruction in EX.
- Stall lasts exactly one cycle per load-use:
  - Next cycle the load sits in mem_e and ex_e is a bubble.
  - The retried consumer therefore forwards with src=1.
- flush and stall asserted together: flush wins, stall = 0, bubble inserted.
- The WB-to-ID same-cycle case is covered by the register file's write-first read port. No entry is kept for WB.
- Reset: ex_e.v = mem_e.v = 0; stall = 0, ex_bubble = 1, all fwd_* = 0. Reset mid-stall drops the stall next cycle.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- When defined:
  - Extra output stall_cnt, 16 bits.
  - Reset to 0.
  - Increments each cycle stall = 1.
  - Saturates at 16'hFFFF with no wrap.
  - Readable by debug logic only.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ADD r1 then ADD r2,r1,r3 back-to-back -> stall=0; next cycle fwd_a_sel=1, fwd_a_src=0, fwd_b_sel=0.
- ADD r1; NOP; SUB r4,r2,r1 -> in SUB's EX cycle fwd_b_sel=1, fwd_b_src=1, fwd_a_sel=0.
- LD r5; ADD r6,r5,r5 -> stall=1 for exactly one cycle, then ex_bubble=1. On retry both operands have sel=1, src=1. Stall counter (if enabled) = 1.
- ADD r3; ADD r3; ADD r7,r3,r0 -> operand A forwards from nearest (src=0); rs2=r0 gives fwd_b_sel=0.
- LD r2 in EX, ADD r1,r2 in ID with flush=1 -> stall=0, next ex_bubble=1, fwd_*=0.
- Writer to r0 followed by reader of r0 -> no stall, fwd_*=0. Assert rst mid-stall -> next cycle stall=0, ex_bubble=1.
